// File: rtl/multiplicador_if.sv
// -----------------------------------------------------------------------------
// multiplicador_if
//   Bundles the multiplier's operand/handshake/result signals so that the core
//   (master) and the multiplier (slave) connect through a single port.
//
//   Signals:
//     MD_in   [WIDTH-1:0]    multiplicand operand        (master -> slave)
//     MR_in   [WIDTH-1:0]    multiplier operand          (master -> slave)
//     init                   start request               (master -> slave)
//     busy                   operation in progress       (slave -> master)
//     ready                  result valid, held          (slave -> master)
//     result  [2*WIDTH-1:0]  full-width product          (slave -> master)
// -----------------------------------------------------------------------------
interface multiplicador_if #(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0]   MD_in;
  logic [WIDTH-1:0]   MR_in;
  logic               init;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  // Requesting side: the core issuing the multiply.
  modport master (
    output MD_in,
    output MR_in,
    output init,
    input  busy,
    input  ready,
    input  result
  );

  // Serving side: the multiplier itself.
  modport slave (
    input  MD_in,
    input  MR_in,
    input  init,
    output busy,
    output ready,
    output result
  );

endinterface

// File: rtl/multiplicador.sv
// -----------------------------------------------------------------------------
// multiplicador
//   Sequential shift-and-add multiplier, companion to the iterative restoring
//   divider. It uses the same init/ready handshake so the RV32I core can issue
//   a multiply exactly as it issues a divide. One multiplier bit is consumed
//   every two clocks (an ADD cycle followed by a SHIFT cycle), so a product is
//   available 2*WIDTH+1 clocks after the accepting edge.
//
//   Ports:
//     clk     clock, all state updates on the rising edge
//     reset   synchronous, active-high reset
//     bus     multiplicador_if.slave:
//               MD_in, MR_in  operands, captured only when init is accepted
//               init          start request, only looked at while idle
//               busy          high from the load edge until the done edge
//               ready         result valid, held until the next accepted init
//               result        2*WIDTH product (low half = MUL, high half =
//                             MULHU, or MULH when signed mode is built)
//
//   Build option:
//     MUL_SIGNED_EN  when defined, operands are two's complement. Magnitudes
//                    are multiplied and the product is negated at the end if
//                    the operand signs differ. When undefined the block is
//                    unsigned only and carries no sign logic.
// -----------------------------------------------------------------------------
module multiplicador #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  multiplicador_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q,  state_d;
  logic [WIDTH-1:0]   md_q,     md_d;
  logic [WIDTH:0]     acc_q,    acc_d;
  logic [WIDTH-1:0]   mr_q,     mr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic               busy_q,   busy_d;
  logic               ready_q,  ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;
`ifdef MUL_SIGNED_EN
  logic               neg_q,    neg_d;
`endif

  logic [WIDTH-1:0]   loadMd;
  logic [WIDTH-1:0]   loadMr;
  logic [2*WIDTH-1:0] product;

  // Operand values to latch at load time. In signed mode the datapath only
  // ever sees magnitudes; the most negative input maps onto 2^(WIDTH-1),
  // which is its correct unsigned magnitude.
`ifdef MUL_SIGNED_EN
  always_comb begin
    loadMd = bus.MD_in[WIDTH-1] ? -bus.MD_in : bus.MD_in;
    loadMr = bus.MR_in[WIDTH-1] ? -bus.MR_in : bus.MR_in;
  end
`else
  always_comb begin
    loadMd = bus.MD_in;
    loadMr = bus.MR_in;
  end
`endif

  // The final product sits in the low WIDTH bits of the accumulator (high
  // half) and in the multiplier register (low half), because the low product
  // bits have been shifted into MR one per SHIFT cycle.
  assign product = {acc_q[WIDTH-1:0], mr_q};

  // Next-state logic for the whole datapath. Every register holds its value
  // unless the current state explicitly updates it, so an idle unit keeps
  // ready and result stable until the next accepted init.
  always_comb begin
    state_d  = state_q;
    md_d     = md_q;
    acc_d    = acc_q;
    mr_d     = mr_q;
    count_d  = count_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    result_d = result_q;
`ifdef MUL_SIGNED_EN
    neg_d    = neg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.init) begin
          md_d    = loadMd;
          mr_d    = loadMr;
          acc_d   = '0;
          count_d = CW'(WIDTH);
          busy_d  = 1'b1;
          ready_d = 1'b0;
`ifdef MUL_SIGNED_EN
          neg_d   = bus.MD_in[WIDTH-1] ^ bus.MR_in[WIDTH-1];
`endif
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        // The extra accumulator bit catches the carry so it can be shifted
        // down into the product on the following SHIFT cycle.
        if (mr_q[0]) begin
          acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, md_q};
        end
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        acc_d   = {1'b0, acc_q[WIDTH:1]};
        mr_d    = {acc_q[0], mr_q[WIDTH-1:1]};
        count_d = count_q - CW'(1);
        state_d = (count_d == '0) ? S_DONE : S_ADD;
      end

      S_DONE: begin
`ifdef MUL_SIGNED_EN
        result_d = neg_q ? -product : product;
`else
        result_d = product;
`endif
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers. Reset wins over everything, including an operation in
  // flight, and clears the result so no partial product is ever visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      md_q     <= '0;
      acc_q    <= '0;
      mr_q     <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
`ifdef MUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      md_q     <= md_d;
      acc_q    <= acc_d;
      mr_q     <= mr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      result_q <= result_d;
`ifdef MUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.ready  = ready_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_multiplicador.sv
// -----------------------------------------------------------------------------
// tb_multiplicador
//   Scoreboard bench for multiplicador (WIDTH=32). Each accepted multiply
//   pushes its reference product and accept cycle; a monitor pops them when
//   ready rises and checks the product and the fixed latency.
// -----------------------------------------------------------------------------
module tb_multiplicador;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 2 * WIDTH + 1;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  logic [2*WIDTH-1:0] expQ[$];
  int                 accQ[$];

  multiplicador_if #(.WIDTH(WIDTH)) bus ();

  multiplicador #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock and a cycle counter used for latency measurement.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the product straight from integer arithmetic.
  function automatic logic [2*WIDTH-1:0] refProduct(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
`ifdef MUL_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    logic [2*WIDTH-1:0] ua;
    logic [2*WIDTH-1:0] ub;
    ua = {{WIDTH{1'b0}}, a};
    ub = {{WIDTH{1'b0}}, b};
    return ua * ub;
`endif
  endfunction

  // One comparison: counts it, reports a failure line when it does not match.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Waits at negedges until the unit is idle; a timeout counts as a failure.
  task automatic waitIdle();
    int budget;
    budget = 0;
    while (bus.busy !== 1'b0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 500) checkOutput("idleTimeout", 64'(bus.busy), 64'd0);
  endtask

  // Issues one multiply and records its expected product and accept cycle.
  task automatic applyStimulus(input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    waitIdle();
    bus.MD_in = a;
    bus.MR_in = b;
    bus.init  = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    checkOutput("busyAfterInit", 64'(bus.busy), 64'd1);
    expQ.push_back(refProduct(a, b));
    accQ.push_back(cyc);
  endtask

  // Monitor: checks each new result against the scoreboard head.
  initial begin : monitor
    logic               readyPrev;
    logic [2*WIDTH-1:0] expVal;
    int                 accCyc;
    readyPrev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ready === 1'b1 && readyPrev !== 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedReady", 64'(bus.ready), 64'd0);
        end else begin
          expVal = expQ.pop_front();
          accCyc = accQ.pop_front();
          checkOutput("result", bus.result, expVal);
          checkOutput("latency", 64'(cyc - accCyc), 64'(LATENCY));
        end
      end
      readyPrev = bus.ready;
    end
  end

  // Main stimulus sequence.
  initial begin : stimulus
    int budget;
    int firstAcc;
    logic busyPrev;

    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    bus.init  = 1'b0;
    bus.MD_in = '0;
    bus.MR_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 64'(bus.busy), 64'd0);
    checkOutput("resetReady", 64'(bus.ready), 64'd0);
    checkOutput("resetResult", bus.result, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed products, including zero operands and carries into the top half.
    applyStimulus(32'd7, 32'd6);
    waitIdle();
    checkOutput("directed7x6", bus.result, 64'h0000_0000_0000_002A);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(32'd0, 32'h1234_5678);
    applyStimulus(32'h8765_4321, 32'd0);
    applyStimulus(32'h8000_0000, 32'd2);
`ifdef MUL_SIGNED_EN
    applyStimulus(32'hFFFF_FFFD, 32'd5);
    applyStimulus(32'h8000_0000, 32'h8000_0000);
    waitIdle();
    checkOutput("signedMinSq", bus.result, 64'h4000_0000_0000_0000);
`else
    waitIdle();
    checkOutput("unsignedDouble", bus.result, 64'h0000_0001_0000_0000);
`endif

    // A second init and new operands mid-operation must change nothing.
    applyStimulus(32'd123, 32'd456);
    repeat (10) @(negedge clk);
    bus.MD_in = 32'hDEAD_BEEF;
    bus.MR_in = 32'hCAFE_F00D;
    bus.init  = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    checkOutput("busyDuringOp", 64'(bus.busy), 64'd1);
    waitIdle();

    // Back-to-back: init held high gives two accepts 2*WIDTH+2 apart.
    bus.MD_in = 32'h0001_0003;
    bus.MR_in = 32'h0000_0011;
    bus.init  = 1'b1;
    @(negedge clk);
    expQ.push_back(refProduct(32'h0001_0003, 32'h0000_0011));
    accQ.push_back(cyc);
    firstAcc = cyc;
    busyPrev = bus.busy;
    budget   = 0;
    while (!(bus.busy === 1'b1 && busyPrev === 1'b0) && budget < 200) begin
      busyPrev = bus.busy;
      @(negedge clk);
      budget++;
    end
    bus.init = 1'b0;
    expQ.push_back(refProduct(32'h0001_0003, 32'h0000_0011));
    accQ.push_back(cyc);
    checkOutput("backToBackGap", 64'(cyc - firstAcc), 64'(LATENCY + 1));
    checkOutput("readyPulse", 64'(bus.ready), 64'd0);
    waitIdle();

    // Reset in the middle of an operation discards it entirely.
    applyStimulus(32'h1111_1111, 32'h2222_2222);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expQ.delete();
    accQ.delete();
    checkOutput("midResetBusy", 64'(bus.busy), 64'd0);
    checkOutput("midResetReady", 64'(bus.ready), 64'd0);
    checkOutput("midResetResult", bus.result, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(32'd3, 32'd3);
    waitIdle();
    checkOutput("afterReset3x3", bus.result, 64'd9);

    // Random operands against the reference model.
    for (int i = 0; i < 10; i++) begin
      applyStimulus($urandom, $urandom);
    end

    // Drain the scoreboard before reporting.
    budget = 0;
    while (expQ.size() != 0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplicador.md
Name: multiplicador

Overview:
- Sequential shift-and-add multiplier; the inverse-operation companion to the team's iterative restoring divider.
- Uses the same init/ready handshake so the RV32I core can issue it the same way it issues a divide.
- Computes the full 2*WIDTH-bit product of two WIDTH-bit operands, one multiplier bit per two clocks.
- Sits beside the divider in the core's arithmetic cores.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
MD_in  input  WIDTH  multiplicand operand
MR_in  input  WIDTH  multiplier operand
init  input  1  start request; sampled only in IDLE
busy  output  1  high from the load edge until the DONE edge
ready  output  1  result valid; held until the next accepted init
result  output  2*WIDTH  product; low half = RV32 MUL, high half = MULHU (MULH with feature)

Behaviour:
- Single clock domain, rising edge only; the next-state update is registered on the same edge.
- Reset (checked first, any state, including mid-operation):
  - state=IDLE, busy=0, ready=0, result=0, internal registers=0.
  - No partial result is ever exposed.
- Internal registers:
  - MD (WIDTH)
  - ACC (WIDTH+1, includes carry)
  - MR (WIDTH; low half of the product shifts in here)
  - count (clog2(WIDTH)+1 bits)
- IDLE:
  - init=0: hold; outputs keep their values (ready/result persist).
  - init=1: MD<=MD_in, MR<=MR_in, ACC<=0, count<=WIDTH, busy<=1, ready<=0; go to ADD.
- ADD:
  - If MR[0]=1, ACC<=ACC[WIDTH-1:0]+MD, with the carry into ACC[WIDTH].
  - Otherwise ACC is unchanged.
  - Go to SHIFT.
- SHIFT:
  - {ACC,MR} <= {1'b0,ACC,MR} >> 1, i.e. the carry bit shifts into the product.
  - count<=count-1.
  - If the decremented count is 0, go to DONE; else go to ADD.
- DONE:
  - result<={ACC[WIDTH-1:0],MR}, ready<=1, busy<=0; go to IDLE.
- Latency:
  - init accepted at edge N; ready=1 and result valid after edge N+2*WIDTH+1 (N+65 for WIDTH=32).
  - Latency is fixed; there is no early termination for zero operands.
- init while busy: ignored, with no restart and no queueing. The held init is re-accepted in the IDLE cycle after DONE.
- Back-to-back: init held high continuously gives one multiply every 2*WIDTH+2 cycles. ready pulses for exactly 1 cycle in that case, because the next load clears it.
- Operands are captured at load; changes to MD_in/MR_in during busy have no effect.
- Illegal state encoding: go to IDLE.
- Arithmetic is mod 2^(2*WIDTH); overflow is impossible since the full product fits.

Optional Feature:
- MUL_SIGNED_EN defined:
  - Operands are two's complement.
  - At load, MD/MR take the magnitude of the inputs (negate if MSB=1); the sign flag neg<=MD_in[WIDTH-1]^MR_in[WIDTH-1].
  - In DONE, result<=neg ? -{ACC,MR} : {ACC,MR} (2*WIDTH-bit negate).
  - Latency is unchanged. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as unsigned; this is correct.
- Not defined: unsigned only; no sign logic or neg register is synthesised.

Test Plan:
1. reset, then MD_in=7, MR_in=6, init pulse: busy=1 next cycle; ready=1 exactly 65 cycles after the accept edge; result=0x000000000000002A.
2. Unsigned MD_in=MR_in=0xFFFFFFFF -> result=0xFFFFFFFE00000001.
3. MD_in=0 or MR_in=0 -> result=0 with the same 65-cycle latency; 0x80000000*2 -> 0x0000000100000000.
4. Second init and operand changes at cycle 10 of an active op -> first result unaffected; no restart. init held high -> ready high for 1 cycle, next product follows 66 cycles after the previous accept.
5. reset asserted at cycle 30 of an op -> next cycle busy=0, ready=0, result=0; fresh op 3*3 then gives 9.
6. With MUL_SIGNED_EN:
   - -3 (0xFFFFFFFD) * 5 -> 0xFFFFFFFFFFFFFFF1.
   - 0xFFFFFFFF*0xFFFFFFFF -> 1.
   - 0x80000000*0x80000000 -> 0x4000000000000000.
